// File: rtl/fb_pkg.sv
// Shared constants, state encoding and bank helper for the framebuffer write scheduler.
// Widths derive from the 512x1024 1-bpp framebuffer with 4-pixel write words.
package fb_pkg;

    localparam int unsigned HEIGHT   = 512;
    localparam int unsigned WIDTH    = 1024;
    localparam int unsigned WIDTH_IN = 4;

    localparam int unsigned YW = $clog2(HEIGHT);
    localparam int unsigned XW = $clog2(WIDTH);
    localparam int unsigned WW = XW - 2;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        DONE
    } fill_state_t;

    function automatic logic [1:0] bank_of(input logic [YW-1:0] y);
        return y[8:7];
    endfunction

endpackage

// File: rtl/fb_fill_walker.sv
// Row-major word cursor for the rectangle fill: captures bounds on load and
// steps x, reloading x0 and incrementing y at the end of each row.
module fb_fill_walker
    import fb_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic          advance,
    input  logic [WW-1:0] x0,
    input  logic [WW-1:0] x1,
    input  logic [YW-1:0] y0,
    input  logic [YW-1:0] y1,
    output logic [WW-1:0] cur_x,
    output logic [YW-1:0] cur_y,
    output logic          last
);

    logic [WW-1:0] x0_q;
    logic [WW-1:0] x1_q;
    logic [YW-1:0] y1_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x0_q  <= '0;
            x1_q  <= '0;
            y1_q  <= '0;
            cur_x <= '0;
            cur_y <= '0;
        end else if (load) begin
            x0_q  <= x0;
            x1_q  <= x1;
            y1_q  <= y1;
            cur_x <= x0;
            cur_y <= y0;
        end else if (advance) begin
            if (cur_x == x1_q) begin
                cur_x <= x0_q;
                cur_y <= cur_y + YW'(1);
            end else begin
                cur_x <= cur_x + WW'(1);
            end
        end
    end

    assign last = (cur_x == x1_q) && (cur_y == y1_q);

endmodule

// File: rtl/fb_write_sched.sv
// Shares the framebuffer write port between the host and the fill engine, round-robin,
// and inserts a one-cycle settle bubble whenever the target bank changes.
module fb_write_sched
    import fb_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                host_valid,
    output logic                host_ready,
    input  logic [XW-1:0]       host_x,
    input  logic [YW-1:0]       host_y,
    input  logic [WIDTH_IN-1:0] host_data,
    input  logic                fill_start,
    input  logic [WW-1:0]       fill_x0,
    input  logic [WW-1:0]       fill_x1,
    input  logic [YW-1:0]       fill_y0,
    input  logic [YW-1:0]       fill_y1,
    input  logic [WIDTH_IN-1:0] fill_pattern,
    output logic                fill_busy,
    output logic                fill_done,
    output logic                fb_enable,
    output logic [XW-1:0]       fb_x,
    output logic [YW-1:0]       fb_y,
    output logic [WIDTH_IN-1:0] fb_data
);

    fill_state_t state, state_next;
    logic        done_hold, done_hold_next;
    logic        load, advance;

    logic [WIDTH_IN-1:0] pattern;
    logic [WW-1:0]       cur_x;
    logic [YW-1:0]       cur_y;
    logic                cur_last;

    logic       rr_fill;
    logic       last_valid;
    logic [1:0] last_bank;

    logic                host_req, fill_req, any_req;
    logic                win_host, win_fill;
    logic                bubble, grant;
    logic [WW-1:0]       win_x;
    logic [YW-1:0]       win_y;
    logic [WIDTH_IN-1:0] win_data;

    fb_fill_walker u_walker (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (load),
        .advance (advance),
        .x0      (fill_x0),
        .x1      (fill_x1),
        .y0      (fill_y0),
        .y1      (fill_y1),
        .cur_x   (cur_x),
        .cur_y   (cur_y),
        .last    (cur_last)
    );

    always_comb begin
        host_req   = host_valid;
        fill_req   = (state == FILL);
        any_req    = host_req || fill_req;
        win_host   = host_req && (!fill_req || !rr_fill);
        win_fill   = fill_req && !win_host;
        win_x      = win_host ? host_x[XW-1:2] : cur_x;
        win_y      = win_host ? host_y : cur_y;
        win_data   = win_host ? host_data : pattern;
        bubble     = any_req && (!last_valid || (bank_of(win_y) != last_bank));
        grant      = any_req && !bubble;
        host_ready = win_host && !bubble;
        advance    = win_fill && !bubble;
    end

    // done_hold delays the fill_done pulse past the final write when the fill did any writes.
    always_comb begin
        state_next     = state;
        done_hold_next = done_hold;
        load           = 1'b0;
        fill_done      = 1'b0;
        fill_busy      = (state != IDLE);
        case (state)
            IDLE: begin
                done_hold_next = 1'b0;
                if (fill_start) begin
                    load = 1'b1;
                    if ((fill_x1 < fill_x0) || (fill_y1 < fill_y0)) begin
                        state_next = DONE;
                    end else begin
                        state_next = FILL;
                    end
                end
            end
            FILL: begin
                if (advance && cur_last) begin
                    state_next     = DONE;
                    done_hold_next = 1'b1;
                end
            end
            DONE: begin
                if (done_hold) begin
                    done_hold_next = 1'b0;
                end else begin
                    fill_done  = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            done_hold <= 1'b0;
            pattern   <= '0;
        end else begin
            state     <= state_next;
            done_hold <= done_hold_next;
            if (load) begin
                pattern <= fill_pattern;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_fill    <= 1'b0;
            last_valid <= 1'b0;
            last_bank  <= '0;
            fb_enable  <= 1'b0;
            fb_x       <= '0;
            fb_y       <= '0;
            fb_data    <= '0;
        end else begin
            fb_enable <= grant;
            if (grant) begin
                rr_fill <= win_host;
                fb_x    <= {win_x, 2'b00};
                fb_y    <= win_y;
                fb_data <= win_data;
            end else if (bubble) begin
                // Row goes out early so the framebuffer's bank select settles before the write.
                fb_y       <= win_y;
                last_valid <= 1'b1;
                last_bank  <= bank_of(win_y);
            end
        end
    end

endmodule

// File: tb/tb_fb_write_sched.sv
// Directed bench for fb_write_sched: expected writes are queued when stimulus is
// driven and popped by a monitor as fb_enable pulses arrive.
module tb_fb_write_sched;
    import fb_pkg::*;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                host_valid = 1'b0;
    logic                host_ready;
    logic [XW-1:0]       host_x = '0;
    logic [YW-1:0]       host_y = '0;
    logic [WIDTH_IN-1:0] host_data = '0;
    logic                fill_start = 1'b0;
    logic [WW-1:0]       fill_x0 = '0;
    logic [WW-1:0]       fill_x1 = '0;
    logic [YW-1:0]       fill_y0 = '0;
    logic [YW-1:0]       fill_y1 = '0;
    logic [WIDTH_IN-1:0] fill_pattern = '0;
    logic                fill_busy;
    logic                fill_done;
    logic                fb_enable;
    logic [XW-1:0]       fb_x;
    logic [YW-1:0]       fb_y;
    logic [WIDTH_IN-1:0] fb_data;

    fb_write_sched dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .host_valid   (host_valid),
        .host_ready   (host_ready),
        .host_x       (host_x),
        .host_y       (host_y),
        .host_data    (host_data),
        .fill_start   (fill_start),
        .fill_x0      (fill_x0),
        .fill_x1      (fill_x1),
        .fill_y0      (fill_y0),
        .fill_y1      (fill_y1),
        .fill_pattern (fill_pattern),
        .fill_busy    (fill_busy),
        .fill_done    (fill_done),
        .fb_enable    (fb_enable),
        .fb_x         (fb_x),
        .fb_y         (fb_y),
        .fb_data      (fb_data)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [XW-1:0]       x;
        logic [YW-1:0]       y;
        logic [WIDTH_IN-1:0] d;
    } wr_t;

    wr_t  host_q[$];
    wr_t  fill_q[$];
    int   wcyc[$];
    int   dcyc[$];
    bit   src_q[$];
    int   ready_cnt = 0;
    int   cyc = 0;
    int   cmp_cnt = 0;
    int   err_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        cmp_cnt++;
        assert (obs === exp) else begin
            err_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endfunction

    always @(negedge clk) begin
        if (rst_n) begin
            if (fb_enable) begin
                wr_t got;
                wr_t exp;
                got = {fb_x, fb_y, fb_data};
                wcyc.push_back(cyc);
                if (host_q.size() == 0 && fill_q.size() == 0) begin
                    check("unexpected_write", 32'(got), 32'hFFFF_FFFF);
                end else if (host_q.size() == 0 ||
                             (fill_q.size() != 0 && got.d == fill_q[0].d)) begin
                    exp = fill_q.pop_front();
                    src_q.push_back(1'b0);
                    check("fill_write", 32'(got), 32'(exp));
                end else begin
                    exp = host_q.pop_front();
                    src_q.push_back(1'b1);
                    check("host_write", 32'(got), 32'(exp));
                end
            end
            if (fill_done) dcyc.push_back(cyc);
            if (host_valid && host_ready) ready_cnt++;
        end
    end

    task automatic clear_logs();
        wcyc.delete();
        dcyc.delete();
        src_q.delete();
        ready_cnt = 0;
    endtask

    task automatic drive_fill(input int x0, input int x1, input int y0, input int y1,
                              input logic [WIDTH_IN-1:0] pat);
        fill_start   = 1'b1;
        fill_x0      = WW'(x0);
        fill_x1      = WW'(x1);
        fill_y0      = YW'(y0);
        fill_y1      = YW'(y1);
        fill_pattern = pat;
        for (int y = y0; y <= y1; y++)
            for (int x = x0; x <= x1; x++)
                fill_q.push_back('{x: XW'(x * 4), y: YW'(y), d: pat});
    endtask

    task automatic wait_fill_idle(input string tag);
        for (int k = 0; k < 600; k++) begin
            @(negedge clk);
            if (!fill_busy) break;
        end
        check(tag, 32'(fill_busy), 32'd0);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin : main
        int s;
        int hidx;
        bit xfer;
        int n;

        // reset state
        #2;
        check("rst_fb_enable", 32'(fb_enable), 32'd0);
        check("rst_fb_x", 32'(fb_x), 32'd0);
        check("rst_fb_y", 32'(fb_y), 32'd0);
        check("rst_fb_data", 32'(fb_data), 32'd0);
        check("rst_host_ready", 32'(host_ready), 32'd0);
        check("rst_fill_busy", 32'(fill_busy), 32'd0);
        check("rst_fill_done", 32'(fill_done), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // single host write: bubble then write
        @(posedge clk); #1;
        clear_logs();
        s = cyc;
        host_valid = 1'b1; host_x = XW'(8); host_y = YW'(5); host_data = 4'hA;
        host_q.push_back('{x: XW'(8), y: YW'(5), d: 4'hA});
        @(negedge clk);
        check("t1_ready_in_bubble", 32'(host_ready), 32'd0);
        @(posedge clk); #1;
        check("t1_bubble_enable", 32'(fb_enable), 32'd0);
        check("t1_bubble_y", 32'(fb_y), 32'd5);
        @(negedge clk);
        check("t1_ready_after_bubble", 32'(host_ready), 32'd1);
        @(posedge clk); #1;
        host_valid = 1'b0;
        repeat (4) @(posedge clk); #1;
        check("t1_write_count", 32'(wcyc.size()), 32'd1);
        if (wcyc.size() > 0) check("t1_write_cycle", 32'(wcyc[0]), 32'(s + 2));
        check("t1_ready_cycles", 32'(ready_cnt), 32'd1);
        check("t1_host_q_empty", 32'(host_q.size()), 32'd0);

        // 3x2 fill from a fresh reset (bank unknown -> one bubble)
        do_reset();
        @(posedge clk); #1;
        clear_logs();
        s = cyc;
        drive_fill(2, 4, 10, 11, 4'hF);
        @(posedge clk); #1;
        fill_start = 1'b0;
        fill_x0 = '0; fill_x1 = '1; fill_y0 = '0; fill_y1 = '1; fill_pattern = 4'h0;
        @(negedge clk);
        check("t2_busy", 32'(fill_busy), 32'd1);
        wait_fill_idle("t2_finish");
        repeat (2) @(posedge clk); #1;
        check("t2_write_count", 32'(wcyc.size()), 32'd6);
        n = wcyc.size();
        for (int i = 0; i < n; i++) check("t2_write_cycle", 32'(wcyc[i]), 32'(s + 3 + i));
        check("t2_done_count", 32'(dcyc.size()), 32'd1);
        if (dcyc.size() > 0 && n > 0) check("t2_done_after_last", 32'(dcyc[0]), 32'(wcyc[n-1] + 1));
        check("t2_fill_q_empty", 32'(fill_q.size()), 32'd0);

        // bank crossing 127 -> 128 costs one idle cycle
        @(posedge clk); #1;
        clear_logs();
        s = cyc;
        drive_fill(0, 0, 126, 129, 4'hF);
        @(posedge clk); #1;
        fill_start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("t3_bubble_enable", 32'(fb_enable), 32'd0);
        check("t3_bubble_y", 32'(fb_y), 32'd128);
        wait_fill_idle("t3_finish");
        repeat (2) @(posedge clk); #1;
        check("t3_write_count", 32'(wcyc.size()), 32'd4);
        if (wcyc.size() == 4) begin
            check("t3_w0", 32'(wcyc[0]), 32'(s + 2));
            check("t3_w1", 32'(wcyc[1]), 32'(s + 3));
            check("t3_w2", 32'(wcyc[2]), 32'(s + 5));
            check("t3_w3", 32'(wcyc[3]), 32'(s + 6));
        end
        check("t3_done_count", 32'(dcyc.size()), 32'd1);

        // fill and continuous host in the same bank alternate
        @(posedge clk); #1;
        clear_logs();
        s = cyc;
        drive_fill(0, 3, 130, 130, 4'h3);
        hidx = 0;
        host_valid = 1'b1; host_x = XW'(0); host_y = YW'(131); host_data = 4'h5;
        host_q.push_back('{x: XW'(0), y: YW'(131), d: 4'h5});
        for (int k = 0; k < 40 && hidx < 4; k++) begin
            @(negedge clk);
            xfer = host_ready;
            @(posedge clk); #1;
            fill_start = 1'b0;
            if (xfer) begin
                hidx++;
                if (hidx < 4) begin
                    host_x = XW'(16 * hidx);
                    host_data = WIDTH_IN'(5 + hidx);
                    host_q.push_back('{x: XW'(16 * hidx), y: YW'(131), d: WIDTH_IN'(5 + hidx)});
                end else begin
                    host_valid = 1'b0;
                end
            end
        end
        host_valid = 1'b0;
        check("t4_host_accepted", 32'(hidx), 32'd4);
        wait_fill_idle("t4_finish");
        repeat (2) @(posedge clk); #1;
        check("t4_write_count", 32'(wcyc.size()), 32'd8);
        n = (wcyc.size() < 8) ? wcyc.size() : 8;
        for (int i = 0; i < n; i++) begin
            check("t4_write_cycle", 32'(wcyc[i]), 32'(s + 1 + i));
            check("t4_source", 32'(src_q[i]), 32'((i % 2) == 0));
        end
        check("t4_host_q_empty", 32'(host_q.size()), 32'd0);
        check("t4_fill_q_empty", 32'(fill_q.size()), 32'd0);
        check("t4_done_count", 32'(dcyc.size()), 32'd1);

        // empty rectangle: immediate done, no writes
        @(posedge clk); #1;
        clear_logs();
        drive_fill(4, 2, 0, 0, 4'h9);
        @(posedge clk); #1;
        fill_start = 1'b0;
        @(negedge clk);
        check("t5_done_pulse", 32'(fill_done), 32'd1);
        check("t5_busy_in_done", 32'(fill_busy), 32'd1);
        @(negedge clk);
        check("t5_done_cleared", 32'(fill_done), 32'd0);
        check("t5_busy_cleared", 32'(fill_busy), 32'd0);
        repeat (3) @(posedge clk); #1;
        check("t5_no_writes", 32'(wcyc.size()), 32'd0);
        check("t5_done_count", 32'(dcyc.size()), 32'd1);

        // reset during a fill aborts it
        @(posedge clk); #1;
        clear_logs();
        drive_fill(0, 15, 200, 210, 4'hC);
        @(posedge clk); #1;
        fill_start = 1'b0;
        repeat (6) @(posedge clk);
        @(negedge clk); #1;
        check("t6_writes_started", 32'(wcyc.size() > 0), 32'd1);
        rst_n = 1'b0;
        #1;
        check("t6_rst_fb_enable", 32'(fb_enable), 32'd0);
        check("t6_rst_fb_x", 32'(fb_x), 32'd0);
        check("t6_rst_fb_y", 32'(fb_y), 32'd0);
        check("t6_rst_fb_data", 32'(fb_data), 32'd0);
        check("t6_rst_fill_busy", 32'(fill_busy), 32'd0);
        check("t6_rst_fill_done", 32'(fill_done), 32'd0);
        fill_q.delete();
        n = wcyc.size();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (10) @(posedge clk); #1;
        check("t6_no_writes_after", 32'(wcyc.size()), 32'(n));
        check("t6_no_done", 32'(dcyc.size()), 32'd0);
        check("t6_idle", 32'(fill_busy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/fb_write_sched.md
# fb_write_sched

Write-side scheduler for the 512x1024 1-bpp framebuffer. Shares the framebuffer's single 4-pixel write port between a host pixel port (valid/ready) and an internal rectangle-fill engine, round-robin when both are active. Sequences the fill as a row-major word walk. Inserts the one-cycle bank-settle bubble the framebuffer's registered bank select requires.

## Interface
- HEIGHT, 512, framebuffer lines; row width YW = $clog2(HEIGHT) = 9
- WIDTH, 1024, pixels per line; column width XW = $clog2(WIDTH) = 10
- WIDTH_IN, 4, pixels per write word; word index width WW = XW-2 = 8

Ports:
- clk  in  1  sole clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- host_valid  in  1  host write request
- host_ready  out  1  host request accepted this cycle
- host_x  in  XW  pixel column; bits [1:0] ignored
- host_y  in  YW  row
- host_data  in  WIDTH_IN  pixel word
- fill_start  in  1  one-cycle start pulse
- fill_x0, fill_x1  in  WW  inclusive word-column bounds
- fill_y0, fill_y1  in  YW  inclusive row bounds
- fill_pattern  in  WIDTH_IN  word written everywhere
- fill_busy  out  1  fill in progress
- fill_done  out  1  one-cycle completion pulse
- fb_enable  out  1  framebuffer write strobe
- fb_x  out  XW  to framebuffer; [1:0] always 0
- fb_y  out  YW  to framebuffer
- fb_data  out  WIDTH_IN  to framebuffer

## Operation
- Fill FSM states: IDLE, FILL, DONE.
  - IDLE: fill_start latches bounds and pattern, sets cursor to (fill_x0, fill_y0), goes to FILL.
  - If fill_x1<fill_x0 or fill_y1<fill_y0, goes to DONE with no writes.
  - FILL: each fill grant writes the cursor word and advances x. At x==fill_x1, x reloads fill_x0 and y increments. The grant at (fill_x1, fill_y1) goes to DONE.
  - DONE: fill_done=1 for one cycle, then IDLE.
- fill_busy=1 in FILL and DONE. fill_start is ignored unless in IDLE.
- Fill bounds and pattern are captured at start. Input changes mid-fill have no effect.
- Arbitration per issue slot:
  - Only one requester active: it wins.
  - Both active: round-robin pointer alternates; pointer flips only on an actual grant.
  - After reset the pointer favours host.
- Bank tracking: bank = y[8:7]. last_bank register plus last_valid flag.
  - Winner's bank differs from last_bank, or last_valid=0: bubble cycle. Drive fb_y = winner y, fb_enable=0, no grant (host_ready=0, fill cursor holds), update last_bank, set last_valid.
  - Next slot re-arbitrates; the same winner is granted because the pointer did not flip.
- host_ready is combinational: high only in a cycle where host wins and no bubble is needed. Transfer occurs on host_valid && host_ready.
- Reset mid-fill aborts: state IDLE, writes stop immediately, no fill_done.

## Timing
- Outputs fb_enable/fb_x/fb_y/fb_data are registered. A grant in cycle N produces fb_enable=1 in cycle N+1 with that word's address/data.
- Bubble: fb_y presents the new row one full cycle before the fb_enable cycle for that row.
- Full-rate streaming within a bank: one write per cycle, no gaps.
- Fill of W words x H rows within one bank, host idle: first write at start+2 (1 bubble when the bank changes), then W*H consecutive writes. fill_done is asserted the cycle after the last fb_enable.
- Crossing a bank boundary (y 127->128, 255->256, 383->384) costs exactly one idle cycle.
- Reset values: fb_enable=0, fb_x=0, fb_y=0, fb_data=0, host_ready=0, fill_busy=0, fill_done=0, last_valid=0, pointer=host.

## Structure
- Package fb_pkg: YW/XW/WW constants derived from defaults, bank extraction helper (y[8:7]), fill state enum.
- One sub-module: fb_fill_walker. It holds the bounds/cursor registers and x/y counters with reload. Inputs: load, advance. Outputs: cursor, last.
- Top holds the FSM, arbiter, bank tracker and output registers.

## Test plan
- Reset, single host write x=8,y=5,data=0xA -> bubble cycle (fb_enable=0, fb_y=5), then fb_enable=1, fb_x=8, fb_y=5, fb_data=0xA; host_ready high exactly one cycle.
- Fill x0=2,x1=4,y0=10,y1=11, pattern 0xF, host idle -> 6 writes in order (8,10),(12,10),(16,10),(8,11),(12,11),(16,11), no gaps after first bubble; fill_done pulse once.
- Fill y0=126,y1=129,x0=x1=0 -> exactly one bubble between the y=127 and y=128 writes; 4 writes total.
- Fill active plus continuous host_valid in same bank -> fb writes alternate host/fill each cycle; no request lost.
- Fill with x1<x0 -> fill_done the cycle after start, zero fb_enable pulses. rst_n asserted mid-fill -> all outputs zero asynchronously, no fill_done afterward.
